fifo_write_ctrl: RTL and testbench

FIFO_WRITE_CTRL -- requirements
Module: fifo_write_ctrl

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_write_ctrl_if.sv | 47 ++++
 rtl/fifo_write_ctrl_sync.sv | 25 ++
 rtl/fifo_write_ctrl.sv | 96 +++++++++
 tb/tb_fifo_write_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray/binary pointer conversion and default sizes.
// Used by both the write-side and read-side pointer controllers.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 4;

    // Wide carrier so one pair of functions serves any pointer width;
    // callers zero-extend in and keep the low bits out.
    localparam int PTR_W = 32;

    typedef logic [PTR_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_write_ctrl_if.sv
// Write-side FIFO bundle: producer handshake, memory port, pointer exchange.
// master = producer / environment side, slave = write controller.
interface fifo_write_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wlevel;
    logic                  overflow;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH:0]   rptr_gray;
    logic [ADDR_WIDTH:0]   wptr_gray;

    modport master (
        output valid,
        output data_in,
        output rptr_gray,
        input  full,
        input  almost_full,
        input  wlevel,
        input  overflow,
        input  wen,
        input  waddr,
        input  wdata,
        input  wptr_gray
    );

    modport slave (
        input  valid,
        input  data_in,
        input  rptr_gray,
        output full,
        output almost_full,
        output wlevel,
        output overflow,
        output wen,
        output waddr,
        output wdata,
        output wptr_gray
    );

endinterface

// File: rtl/fifo_write_ctrl_sync.sv
// Two-flop synchronizer bringing the Gray read pointer into wclk.
// Nothing but the two flop stages sits on this crossing.
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             wclk,
    input  logic             wreset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back capture stages, cleared by the async reset
    always_ff @(posedge wclk or posedge wreset) begin
        if (wreset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-side controller of an async FIFO: pointer, full/level flags,
// overflow tracking and read-pointer synchronizer. Storage is external.
module fifo_write_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_MARGIN  = 2
) (
    input  logic          wclk,
    input  logic          wreset,
    fifo_write_ctrl_if.slave bus
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] AF_LVL = PW'(DEPTH - AF_MARGIN);

    logic [PW-1:0] wptr_bin;
    logic [PW-1:0] wptr_bin_next;
    logic [PW-1:0] wptr_gray_q;
    logic [PW-1:0] rq2;
    logic [PW-1:0] wlevel_q;
    logic [PW-1:0] wlevel_next;
    logic          full_q;
    logic          full_next;
    logic          overflow_q;
    logic          accepted;

    ptr_t gray_next_w;
    ptr_t full_tgt_w;
    ptr_t rbin_w;
    ptr_t lvl_w;
    logic unused_hi;

    sync_2ff #(
        .WIDTH (PW)
    ) u_sync (
        .wclk   (wclk),
        .wreset (wreset),
        .d      (bus.rptr_gray),
        .q      (rq2)
    );

    // Accept a word when offered and there is room; reset kills it
    always_comb begin
        accepted      = bus.valid && !full_q && !wreset;
        wptr_bin_next = wptr_bin + PW'(accepted);
    end

    // Next-state flags: full compares next Gray pointer with the
    // synchronized read pointer (top two bits inverted); level is
    // the binary distance, using the stale read pointer so it only
    // ever over-estimates occupancy.
    always_comb begin
        gray_next_w = bin2gray(ptr_t'(wptr_bin_next));
        full_tgt_w  = ptr_t'({~rq2[PW-1:PW-2], rq2[PW-3:0]});
        full_next   = (gray_next_w == full_tgt_w);
        rbin_w      = gray2bin(ptr_t'(rq2));
        lvl_w       = ptr_t'(wptr_bin_next) - rbin_w;
        wlevel_next = lvl_w[PW-1:0];
        unused_hi   = ^lvl_w[PTR_W-1:PW];
    end

    // Pointer, flag and level registers
    always_ff @(posedge wclk or posedge wreset) begin
        if (wreset) begin
            wptr_bin    <= '0;
            wptr_gray_q <= '0;
            full_q      <= 1'b0;
            wlevel_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wptr_bin    <= wptr_bin_next;
            wptr_gray_q <= gray_next_w[PW-1:0];
            full_q      <= full_next;
            wlevel_q    <= wlevel_next;
            if (bus.valid && full_q) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Zero-latency memory port and registered status outputs
    always_comb begin
        bus.wen         = accepted;
        bus.waddr       = wptr_bin[ADDR_WIDTH-1:0];
        bus.wdata       = bus.data_in;
        bus.wptr_gray   = wptr_gray_q;
        bus.full        = full_q;
        bus.wlevel      = wlevel_q;
        bus.almost_full = (wlevel_q >= AF_LVL);
        bus.overflow    = overflow_q;
    end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed self-checking bench for fifo_write_ctrl (DATA 8, ADDR 4).
// Inputs change on the falling edge; outputs are checked away from rising edges.
module tb_fifo_write_ctrl;

    logic wclk;
    logic wreset;

    int ntotal = 0;
    int npass  = 0;
    int nfail  = 0;

    fifo_write_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    fifo_write_ctrl #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .AF_MARGIN  (2)
    ) dut (
        .wclk   (wclk),
        .wreset (wreset),
        .bus    (bus.slave)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] g5(input int b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    task automatic chk_reset_state(input string tag);
        chk({tag, "_full"}, 32'(bus.full), 32'd0);
        chk({tag, "_af"}, 32'(bus.almost_full), 32'd0);
        chk({tag, "_lvl"}, 32'(bus.wlevel), 32'd0);
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
        chk({tag, "_wg"}, 32'(bus.wptr_gray), 32'd0);
        chk({tag, "_wen"}, 32'(bus.wen), 32'd0);
    endtask

    // Offer one word; check the zero-latency memory port before the edge
    task automatic wr(input int d, input int exp_addr, input string tag);
        bus.valid   = 1'b1;
        bus.data_in = d[7:0];
        #1;
        chk({tag, "_wen"}, 32'(bus.wen), 32'd1);
        chk({tag, "_waddr"}, 32'(bus.waddr), 32'(exp_addr));
        chk({tag, "_wdata"}, 32'(bus.wdata), 32'(d[7:0]));
        @(negedge wclk);
    endtask

    initial begin
        bus.valid     = 1'b0;
        bus.data_in   = '0;
        bus.rptr_gray = '0;
        wreset        = 1'b1;
        @(negedge wclk);
        @(negedge wclk);
        chk_reset_state("rst");
        wreset = 1'b0;

        // Fill with the read pointer parked at 0; level/almost_full steps
        for (int i = 0; i < 13; i++) wr(i, i, "fill");
        bus.valid = 1'b0;
        #1;
        chk("lvl13", 32'(bus.wlevel), 32'd13);
        chk("af13", 32'(bus.almost_full), 32'd0);
        wr(13, 13, "fill");
        bus.valid = 1'b0;
        #1;
        chk("lvl14", 32'(bus.wlevel), 32'd14);
        chk("af14", 32'(bus.almost_full), 32'd1);
        wr(14, 14, "fill");
        bus.valid = 1'b0;
        #1;
        chk("full15", 32'(bus.full), 32'd0);
        wr(15, 15, "fill");
        bus.valid = 1'b0;
        #1;
        chk("full16", 32'(bus.full), 32'd1);
        chk("wg16", 32'(bus.wptr_gray), 32'b11000);
        chk("lvl16", 32'(bus.wlevel), 32'd16);

        // Keep pushing while full: nothing written, overflow latches
        for (int i = 0; i < 3; i++) begin
            bus.valid   = 1'b1;
            bus.data_in = 8'hAA;
            #1;
            chk("ovf_wen", 32'(bus.wen), 32'd0);
            @(negedge wclk);
        end
        bus.valid = 1'b0;
        #1;
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        chk("ovf_full", 32'(bus.full), 32'd1);
        chk("ovf_wg", 32'(bus.wptr_gray), 32'b11000);
        @(negedge wclk);
        chk("ovf_hold", 32'(bus.overflow), 32'd1);

        // Read side frees one slot: full drops on the third edge
        bus.rptr_gray = 5'b00001;
        @(negedge wclk);
        chk("rel_e1", 32'(bus.full), 32'd1);
        @(negedge wclk);
        chk("rel_e2", 32'(bus.full), 32'd1);
        @(negedge wclk);
        chk("rel_e3", 32'(bus.full), 32'd0);
        wr(8'h55, 0, "rel");
        bus.valid = 1'b0;
        #1;
        chk("refull", 32'(bus.full), 32'd1);
        chk("refull_lvl", 32'(bus.wlevel), 32'd16);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Reset clears the sticky overflow and everything else
        @(negedge wclk);
        wreset        = 1'b1;
        bus.rptr_gray = '0;
        #1;
        chk_reset_state("rst2");
        @(negedge wclk);
        wreset = 1'b0;

        // Nine writes, then reset lands in the middle of the tenth
        for (int i = 0; i < 9; i++) wr(i + 8'h20, i, "pre");
        #1;
        chk("pre_lvl", 32'(bus.wlevel), 32'd9);
        chk("pre_wg", 32'(bus.wptr_gray), 32'b01101);
        bus.valid   = 1'b1;
        bus.data_in = 8'h77;
        #2;
        wreset = 1'b1;
        #1;
        chk_reset_state("midrst");
        chk("midrst_waddr", 32'(bus.waddr), 32'd0);
        @(negedge wclk);
        @(negedge wclk);
        wreset = 1'b0;

        // Read side lags by one word for 40 writes: wraps, never full
        for (int i = 0; i < 40; i++) begin
            bus.rptr_gray = g5(i > 0 ? i - 1 : 0);
            chk("wrap_full", 32'(bus.full), 32'd0);
            wr(i, i % 16, "wrap");
        end
        bus.valid = 1'b0;
        #1;
        chk("wrap_wg", 32'(bus.wptr_gray), 32'b01100);
        chk("wrap_nofull", 32'(bus.full), 32'd0);
        chk("wrap_ovf", 32'(bus.overflow), 32'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
